fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters (router input ports), N >= 2.
REQ-002 SHALL have parameter DATA_W, default 32: flit width in bits.
REQ-003 SHALL have parameter CNT_W, default 16: width of the completed-packet counter.
REQ-004 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1: synchronous reset, active-high, sampled on the rising edge of CLK.
REQ-006 SHALL have port REQ_VALID, input, N: per-requester flit valid.
REQ-007 SHALL have port REQ_DATA, input, N*DATA_W: per-requester flit; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port REQ_TAIL, input, N: per-requester last-flit-of-packet flag, qualified by REQ_VALID.
REQ-009 SHALL have port REQ_READY, output, N: per-requester flit accepted this cycle when high together with REQ_VALID.
REQ-010 SHALL have port WFULL, input, 1: full flag from the downstream FIFO write side.
REQ-011 SHALL have port WINC, output, 1: write strobe to the downstream FIFO.
REQ-012 SHALL have port WDATA, output, DATA_W: write data to the downstream FIFO.
REQ-013 SHALL have port GRANT, output, N: one-hot current owner, all-zero when no owner.
REQ-014 SHALL have port BUSY, output, 1: high while a packet owns the FIFO.
REQ-015 SHALL have port PKT_CNT, output, CNT_W: count of completed packets.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (no owner) and LOCK (owner = GRANT index g).
REQ-017 SHALL keep a registered round-robin pointer P in 0..N-1; the search order in IDLE is P, P+1, ..., P+N-1, mod N.
REQ-018 In IDLE with any REQ_VALID high, SHALL register GRANT to the first valid requester in search order and go to LOCK on the next edge; arbitration latency is 1 cycle, and no flit transfers in IDLE.
REQ-019 In IDLE, SHALL drive REQ_READY = 0, WINC = 0 and GRANT = 0.
REQ-020 In LOCK, SHALL drive REQ_READY[g] = ~WFULL and REQ_READY[i != g] = 0.
REQ-021 In LOCK, SHALL drive WINC = REQ_VALID[g] & ~WFULL, combinationally, with no register stage.
REQ-022 SHALL drive WDATA = REQ_DATA slice g in LOCK, and zero in IDLE.
REQ-023 A transfer SHALL be WINC = 1; WINC SHALL never be high while WFULL = 1.
REQ-024 On a transfer with REQ_TAIL[g] = 1, SHALL go to IDLE, set P = (g+1) mod N (wrapping N-1 to 0), clear GRANT and increment PKT_CNT by 1, wrapping at 2^CNT_W.
REQ-025 Wormhole hold: in LOCK, SHALL keep GRANT unchanged while REQ_VALID[g] = 0 or WFULL = 1, with no timeout and no preemption.
REQ-026 SHALL treat a single-flit packet (TAIL on first flit) as a complete packet: one transfer, then IDLE.
REQ-027 SHALL ignore other requesters' VALID and TAIL during LOCK; they wait, with no data loss.
REQ-028 SHALL drive BUSY = (state == LOCK); GRANT SHALL be one-hot or zero at all times.

Reset
REQ-029 On RST = 1 at a CLK edge, SHALL set state = IDLE, P = 0, GRANT = 0 and PKT_CNT = 0, giving BUSY = 0, WINC = 0, REQ_READY = 0 and WDATA = 0 from the next cycle.
REQ-030 RST SHALL take priority over any transfer in the same cycle; a packet in flight is abandoned, with no WINC and no PKT_CNT increment.
REQ-031 SHALL use no asynchronous reset and no other clock.

Verification
REQ-032 Reset: hold RST 2 cycles with all REQ_VALID = 1 -> GRANT = 0, WINC = 0, PKT_CNT = 0; 1 cycle after RST falls -> GRANT = 4'b0001.
REQ-033 Round-robin: N = 4, all requesters present 1-flit packets continuously, WFULL = 0 -> grant order 0,1,2,3,0; each grant is 1 IDLE cycle plus 1 transfer cycle; PKT_CNT = 5 after 10 cycles.
REQ-034 Wormhole: req1 sends 3 flits (A1, A2, A3 with TAIL on A3) while req2 is valid throughout -> WDATA sequence A1, A2, A3 on WINC; GRANT moves to 4'b0100 only after A3.
REQ-035 Backpressure: WFULL = 1 for 3 cycles mid-packet -> WINC = 0 and REQ_READY[g] = 0 for those cycles, GRANT held, and no flit is dropped or duplicated after WFULL falls.
REQ-036 Bubble: owner drops VALID for 2 cycles mid-packet while others are valid -> GRANT is unchanged and WINC = 0 for those cycles.
REQ-037 Reset mid-packet plus wrap: RST after flit 2 of 4 -> state IDLE and PKT_CNT unchanged at 0; separately, PKT_CNT preloaded via 2^CNT_W packets wraps to 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin wormhole arbiter that lets N requesters (router input ports)
// share the write side of one downstream FIFO. A requester wins in IDLE,
// then owns the FIFO until the flit marked TAIL has been written. Flits
// move combinationally from the owner to the FIFO whenever it is not full.
//
// Ports
//   CLK        single clock, all state changes on the rising edge
//   RST        synchronous active-high reset
//   REQ_VALID  [N]         per-requester flit valid
//   REQ_DATA   [N*DATA_W]  per-requester flit, requester i at [i*DATA_W +: DATA_W]
//   REQ_TAIL   [N]         per-requester last-flit flag (qualified by REQ_VALID)
//   REQ_READY  [N]         per-requester flit accepted (with REQ_VALID)
//   WFULL      downstream FIFO full
//   WINC       downstream FIFO write strobe
//   WDATA      [DATA_W]    downstream FIFO write data
//   GRANT      [N]         one-hot current owner, zero when idle
//   BUSY       high while a packet owns the FIFO
//   PKT_CNT    [CNT_W]     completed packet count, wraps
module fifo_wr_arbiter #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N-1:0]        REQ_VALID,
  input  logic [N*DATA_W-1:0] REQ_DATA,
  input  logic [N-1:0]        REQ_TAIL,
  output logic [N-1:0]        REQ_READY,
  input  logic                WFULL,
  output logic                WINC,
  output logic [DATA_W-1:0]   WDATA,
  output logic [N-1:0]        GRANT,
  output logic                BUSY,
  output logic [CNT_W-1:0]    PKT_CNT
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     own_idx;
  logic [N-1:0]      grant_r;
  logic [CNT_W-1:0]  pkt_cnt;

  logic [PW-1:0]     sel_idx;
  logic              sel_found;
  logic [PW:0]       cand;
  logic              owner_vld;
  logic              owner_tail;
  logic              xfer;

  // Search requesters starting at the round-robin pointer, wrapping mod N.
  // cand is one bit wider so rr_ptr + k (at most 2N-2) never overflows.
  always_comb begin
    sel_idx   = rr_ptr;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (!sel_found && REQ_VALID[cand[PW-1:0]]) begin
        sel_idx   = cand[PW-1:0];
        sel_found = 1'b1;
      end
    end
  end

  // grant_r is zero in IDLE, so masking with it selects only the owner.
  assign owner_vld  = |(REQ_VALID & grant_r);
  assign owner_tail = |(REQ_TAIL  & grant_r);

  // Reset wins over a same-cycle transfer: the flit is neither written nor
  // acknowledged, so the abandoned packet never half-commits.
  assign xfer = (state == LOCK) && owner_vld && !WFULL && !RST;

  assign WINC      = xfer;
  assign REQ_READY = ((state == LOCK) && !WFULL && !RST) ? grant_r : '0;
  assign GRANT     = grant_r;
  assign BUSY      = (state == LOCK);
  assign PKT_CNT   = pkt_cnt;

  // One-hot AND-OR mux; yields zero when there is no owner.
  always_comb begin
    WDATA = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_r[i]) WDATA = WDATA | REQ_DATA[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      own_idx <= '0;
      grant_r <= '0;
      pkt_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            state   <= LOCK;
            own_idx <= sel_idx;
            grant_r <= N'(1) << sel_idx;
          end
        end
        LOCK: begin
          // Wormhole hold: ownership ends only with the tail transfer.
          if (xfer && owner_tail) begin
            state   <= IDLE;
            grant_r <= '0;
            rr_ptr  <= (own_idx == LAST_IDX) ? '0 : own_idx + PW'(1);
            pkt_cnt <= pkt_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          grant_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ_VALID;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]    REQ_TAIL;
  logic [N-1:0]    REQ_READY;
  logic            WFULL;
  logic            WINC;
  logic [DW-1:0]   WDATA;
  logic [N-1:0]    GRANT;
  logic            BUSY;
  logic [CW-1:0]   PKT_CNT;

  fifo_wr_arbiter #(.N(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .REQ_TAIL(REQ_TAIL), .REQ_READY(REQ_READY), .WFULL(WFULL), .WINC(WINC),
    .WDATA(WDATA), .GRANT(GRANT), .BUSY(BUSY), .PKT_CNT(PKT_CNT)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int pkt_id   = 0;

  logic [DW-1:0] src_d [N][$];
  logic          src_t [N][$];
  logic [DW-1:0] sent  [N][$];
  logic [DW-1:0] mon_d [$];
  logic [N-1:0]  mon_g [$];

  task automatic do_reset();
    RST = 1'b1; REQ_VALID = '0; REQ_TAIL = '0; REQ_DATA = '0; WFULL = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_d[i].delete(); src_t[i].delete(); sent[i].delete();
    end
    mon_d.delete(); mon_g.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic push_pkt(input int r, input int len);
    logic [DW-1:0] d;
    for (int s = 0; s < len; s++) begin
      d = {8'(r), 8'(pkt_id), 16'(s)};
      src_d[r].push_back(d);
      src_t[r].push_back(s == len - 1);
      sent[r].push_back(d);
    end
    pkt_id++;
  endtask

  task automatic drive_sources(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (src_d[i].size() > 0 && mask[i]) begin
        REQ_VALID[i] = 1'b1;
        REQ_DATA[i*DW +: DW] = src_d[i][0];
        REQ_TAIL[i] = src_t[i][0];
      end else begin
        REQ_VALID[i] = 1'b0;
        REQ_DATA[i*DW +: DW] = '0;
        REQ_TAIL[i] = 1'b0;
      end
    end
  endtask

  // Called at the falling edge: log writes, then pop accepted flits.
  task automatic sample_and_advance();
    logic [N-1:0] hs;
    if (WINC === 1'b1) begin
      mon_d.push_back(WDATA);
      mon_g.push_back(GRANT);
    end
    hs = REQ_VALID & REQ_READY;
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] === 1'b1 && src_d[i].size() > 0) begin
        void'(src_d[i].pop_front());
        void'(src_t[i].pop_front());
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ_VALID = '1; REQ_TAIL = '1; REQ_DATA = {N{32'h5A5A_1234}}; WFULL = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (GRANT !== '0) begin failures++; $display("FAIL rst_grant: got %b expected 0000", GRANT); end
    checks++; if (WINC !== 1'b0) begin failures++; $display("FAIL rst_winc: got %b expected 0", WINC); end
    checks++; if (PKT_CNT !== '0) begin failures++; $display("FAIL rst_cnt: got %0d expected 0", PKT_CNT); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", BUSY); end
    checks++; if (REQ_READY !== '0) begin failures++; $display("FAIL rst_ready: got %b expected 0000", REQ_READY); end
    checks++; if (WDATA !== '0) begin failures++; $display("FAIL rst_wdata: got %h expected 0", WDATA); end
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (GRANT !== 4'b0001) begin failures++; $display("FAIL rst_first_grant: got %b expected 0001", GRANT); end
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL rst_first_busy: got %b expected 1", BUSY); end
    do_reset();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int idx;
    logic [N-1:0] eg;
    do_reset();
    REQ_VALID = '1; REQ_TAIL = '1; WFULL = 1'b0;
    for (int i = 0; i < N; i++) REQ_DATA[i*DW +: DW] = 32'hA0 + i;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (c % 2 == 0) begin
        checks++; if (GRANT !== '0) begin failures++; $display("FAIL rr_idle_grant c=%0d: got %b expected 0000", c, GRANT); end
        checks++; if (WINC !== 1'b0) begin failures++; $display("FAIL rr_idle_winc c=%0d: got %b expected 0", c, WINC); end
      end else begin
        idx = order[c/2];
        eg = N'(1) << idx;
        checks++; if (GRANT !== eg) begin failures++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, GRANT, eg); end
        checks++; if (WINC !== 1'b1) begin failures++; $display("FAIL rr_winc c=%0d: got %b expected 1", c, WINC); end
        checks++; if (WDATA !== 32'hA0 + idx) begin failures++; $display("FAIL rr_wdata c=%0d: got %h expected %h", c, WDATA, 32'hA0 + idx); end
      end
      @(posedge CLK); #1;
    end
    REQ_VALID = '0;
    @(negedge CLK);
    checks++; if (PKT_CNT !== CW'(5)) begin failures++; $display("FAIL rr_cnt: got %0d expected 5", PKT_CNT); end
  endtask

  task automatic test_wormhole();
    logic [DW-1:0] a [3];
    logic [DW-1:0] b;
    logic a_done;
    do_reset();
    push_pkt(1, 3);
    push_pkt(2, 1);
    for (int s = 0; s < 3; s++) a[s] = sent[1][s];
    b = sent[2][0];
    a_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive_sources('1);
      @(negedge CLK);
      checks++;
      if (!a_done && GRANT === 4'b0100) begin
        failures++; $display("FAIL worm_early_grant c=%0d: got %b expected not 0100", c, GRANT);
      end
      if (WINC === 1'b1 && WDATA === a[2]) a_done = 1'b1;
      sample_and_advance();
    end
    checks++;
    if (mon_d.size() != 4) begin
      failures++; $display("FAIL worm_count: got %0d expected 4", mon_d.size());
    end else begin
      for (int s = 0; s < 3; s++) begin
        checks++; if (mon_d[s] !== a[s]) begin failures++; $display("FAIL worm_seq%0d: got %h expected %h", s, mon_d[s], a[s]); end
      end
      checks++; if (mon_d[3] !== b) begin failures++; $display("FAIL worm_next: got %h expected %h", mon_d[3], b); end
      checks++; if (mon_g[3] !== 4'b0100) begin failures++; $display("FAIL worm_next_grant: got %b expected 0100", mon_g[3]); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_q [$];
    do_reset();
    push_pkt(0, 4);
    push_pkt(1, 2);
    exp_q = {sent[0], sent[1]};
    for (int c = 0; c < 14; c++) begin
      drive_sources('1);
      WFULL = (c >= 3 && c < 6);
      @(negedge CLK);
      checks++; if (WINC === 1'b1 && WFULL) begin failures++; $display("FAIL bp_winc_full c=%0d: got WINC=1 expected 0", c); end
      if (c >= 3 && c < 6) begin
        checks++; if (REQ_READY[0] !== 1'b0) begin failures++; $display("FAIL bp_ready c=%0d: got %b expected 0", c, REQ_READY[0]); end
        checks++; if (GRANT !== 4'b0001) begin failures++; $display("FAIL bp_grant c=%0d: got %b expected 0001", c, GRANT); end
      end
      sample_and_advance();
    end
    WFULL = 1'b0;
    checks++;
    if (mon_d.size() != exp_q.size()) begin
      failures++; $display("FAIL bp_count: got %0d expected %0d", mon_d.size(), exp_q.size());
    end else begin
      for (int s = 0; s < exp_q.size(); s++) begin
        checks++; if (mon_d[s] !== exp_q[s]) begin failures++; $display("FAIL bp_seq%0d: got %h expected %h", s, mon_d[s], exp_q[s]); end
      end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    push_pkt(0, 4);
    push_pkt(1, 2);
    push_pkt(2, 1);
    for (int c = 0; c < 14; c++) begin
      drive_sources((c == 3 || c == 4) ? 4'b1110 : 4'b1111);
      @(negedge CLK);
      if (c == 3 || c == 4) begin
        checks++; if (GRANT !== 4'b0001) begin failures++; $display("FAIL bub_grant c=%0d: got %b expected 0001", c, GRANT); end
        checks++; if (WINC !== 1'b0) begin failures++; $display("FAIL bub_winc c=%0d: got %b expected 0", c, WINC); end
      end
      sample_and_advance();
    end
    checks++;
    if (mon_d.size() != 7) begin
      failures++; $display("FAIL bub_count: got %0d expected 7", mon_d.size());
    end else begin
      for (int s = 0; s < 4; s++) begin
        checks++; if (mon_d[s] !== sent[0][s]) begin failures++; $display("FAIL bub_seq%0d: got %h expected %h", s, mon_d[s], sent[0][s]); end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    push_pkt(2, 4);
    // c0 arbitrate, c1 flit 1, c2 flit 2, c3 reset
    for (int c = 0; c < 3; c++) begin
      drive_sources('1);
      @(negedge CLK);
      sample_and_advance();
    end
    drive_sources('1);
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (WINC !== 1'b0) begin failures++; $display("FAIL rmid_winc: got %b expected 0", WINC); end
    sample_and_advance();
    RST = 1'b0;
    REQ_VALID = '0;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b expected 0", BUSY); end
    checks++; if (GRANT !== '0) begin failures++; $display("FAIL rmid_grant: got %b expected 0000", GRANT); end
    checks++; if (PKT_CNT !== '0) begin failures++; $display("FAIL rmid_cnt: got %0d expected 0", PKT_CNT); end
    checks++; if (mon_d.size() != 2) begin failures++; $display("FAIL rmid_flits: got %0d expected 2", mon_d.size()); end
    @(posedge CLK); #1;
  endtask

  task automatic test_cnt_wrap();
    logic [CW-1:0] ec;
    do_reset();
    for (int p = 0; p < 16; p++) push_pkt(3, 1);
    // One single-flit packet completes every two cycles.
    for (int c = 0; c < 34; c++) begin
      drive_sources('1);
      @(negedge CLK);
      ec = CW'((c / 2) % 16);
      checks++; if (PKT_CNT !== ec) begin failures++; $display("FAIL wrap_cnt c=%0d: got %0d expected %0d", c, PKT_CNT, ec); end
      sample_and_advance();
    end
    @(negedge CLK);
    checks++; if (PKT_CNT !== '0) begin failures++; $display("FAIL wrap_final: got %0d expected 0", PKT_CNT); end
    checks++; if (mon_d.size() != 16) begin failures++; $display("FAIL wrap_pkts: got %0d expected 16", mon_d.size()); end
    @(posedge CLK); #1;
  endtask

  task automatic test_random();
    int owner, rr, cnt, cyc, pend, pick, ii;
    logic [N-1:0] mask, eg, er;
    logic ew;
    logic [DW-1:0] ed;
    logic [DW-1:0] recv [$];
    do_reset();
    owner = -1; rr = 0; cnt = 0; cyc = 0;
    for (int r = 0; r < N; r++)
      for (int p = 0; p < 6; p++) push_pkt(r, 1 + int'($urandom % 5));
    pend = 1;
    while (cyc < 1500 && (pend > 0 || owner >= 0)) begin
      for (int i = 0; i < N; i++) mask[i] = ($urandom % 4) != 0;
      drive_sources(mask);
      WFULL = ($urandom % 5) == 0;
      if (owner < 0) begin
        eg = '0; er = '0; ew = 1'b0; ed = '0;
      end else begin
        eg = N'(1) << owner;
        er = WFULL ? '0 : eg;
        ew = REQ_VALID[owner] && !WFULL;
        ed = REQ_DATA[owner*DW +: DW];
      end
      @(negedge CLK);
      checks++; if (GRANT !== eg) begin failures++; $display("FAIL rnd_grant cyc=%0d: got %b expected %b", cyc, GRANT, eg); end
      checks++; if (REQ_READY !== er) begin failures++; $display("FAIL rnd_ready cyc=%0d: got %b expected %b", cyc, REQ_READY, er); end
      checks++; if (WINC !== ew) begin failures++; $display("FAIL rnd_winc cyc=%0d: got %b expected %b", cyc, WINC, ew); end
      checks++; if (WDATA !== ed) begin failures++; $display("FAIL rnd_wdata cyc=%0d: got %h expected %h", cyc, WDATA, ed); end
      checks++; if (BUSY !== (owner >= 0)) begin failures++; $display("FAIL rnd_busy cyc=%0d: got %b expected %b", cyc, BUSY, owner >= 0); end
      checks++; if (PKT_CNT !== CW'(cnt)) begin failures++; $display("FAIL rnd_cnt cyc=%0d: got %0d expected %0d", cyc, PKT_CNT, CW'(cnt)); end
      if (owner < 0) begin
        pick = -1;
        for (int k = 0; k < N; k++) begin
          ii = (rr + k) % N;
          if (pick < 0 && REQ_VALID[ii]) pick = ii;
        end
        owner = pick;
      end else if (ew && REQ_TAIL[owner]) begin
        rr = (owner + 1) % N;
        owner = -1;
        cnt++;
      end
      sample_and_advance();
      cyc++;
      pend = 0;
      for (int i = 0; i < N; i++) pend += src_d[i].size();
    end
    WFULL = 1'b0;
    REQ_VALID = '0;
    checks++; if (pend > 0 || owner >= 0) begin failures++; $display("FAIL rnd_timeout: got %0d flits pending expected 0", pend); end
    for (int r = 0; r < N; r++) begin
      recv.delete();
      foreach (mon_d[s]) if (mon_d[s][31:24] == 8'(r)) recv.push_back(mon_d[s]);
      checks++;
      if (recv.size() != sent[r].size()) begin
        failures++; $display("FAIL rnd_e2e_count r=%0d: got %0d expected %0d", r, recv.size(), sent[r].size());
      end else begin
        foreach (recv[s]) begin
          checks++; if (recv[s] !== sent[r][s]) begin failures++; $display("FAIL rnd_e2e r=%0d s=%0d: got %h expected %h", r, s, recv[s], sent[r][s]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wormhole();
    test_backpressure();
    test_bubble();
    test_reset_mid_packet();
    test_cnt_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
